rx_pkt_drop_fifo: RTL and testbench
===================================

# rx_pkt_drop_fifo

Receive-side packet buffer between the CMAC RX stream and the user RX pipeline. The CMAC RX interface cannot be backpressured, so this block stores each incoming frame speculatively and releases it downstream only after its last beat arrives error-free. Frames with a bad FCS, frames arriving while the link is not aligned, and frames that overflow the buffer are discarded whole, so no partial frame ever reaches the user side. Per-packet accept and drop counters are provided for status readout.

## Interface
- DATA_WIDTH, 512, stream data width in bits; keep width is DATA_WIDTH/8
- DEPTH, 64, buffer depth in beats; power of two, ≥4
- CNT_WIDTH, 32, width of the status counters
- net_clk  in  1  clock for all logic
- sys_reset  in  1  reset, asynchronous, active-high
- rx_aligned  in  1  CMAC lane alignment status
- s_axis_tvalid  in  1  input beat valid; there is no tready
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tkeep  in  DATA_WIDTH/8  input byte enables
- s_axis_tlast  in  1  input end of frame
- s_axis_tuser  in  1  frame error flag (bad FCS); sampled only on the tlast beat
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  DATA_WIDTH/8  output byte enables
- m_axis_tlast  out  1  output end of frame
- pkt_count  out  CNT_WIDTH  frames committed; saturates at all-ones
- drop_count  out  CNT_WIDTH  frames dropped; saturates at all-ones

## Operation
- **Storage:** DEPTH-entry RAM holding {tdata, tkeep, tlast}.
- **Pointers:** wr_ptr (speculative), commit_ptr and rd_ptr, each log2(DEPTH)+1 bits; comparisons are modulo wrap.
- **Full and empty:**
  - full = (wr_ptr − rd_ptr == DEPTH), using registered values.
  - A slot freed by a read in the same cycle is not usable until the next cycle.
  - empty = (rd_ptr == commit_ptr).
- **Write FSM states:** IDLE (between frames), RECV (inside an accepted frame), DROP (discarding the rest of a frame).
- **Per input beat, evaluated in priority order:**
  1. State DROP: discard the beat. On tlast go to IDLE. No counter changes.
  2. State IDLE and rx_aligned=0: discard the frame and increment drop_count. If tlast, stay in IDLE; otherwise go to DROP.
  3. State RECV and rx_aligned=0, or full=1 (states IDLE/RECV): rewind wr_ptr to commit_ptr and increment drop_count. If tlast go to IDLE, otherwise go to DROP.
  4. Otherwise, write the beat and increment wr_ptr.
     - If tlast and tuser=1: rewind wr_ptr to commit_ptr, increment drop_count, go to IDLE.
     - If tlast and tuser=0: set commit_ptr to the new wr_ptr, increment pkt_count, go to IDLE.
     - If not tlast: go to RECV.
- Each frame increments exactly one of pkt_count or drop_count, exactly once.
- A frame longer than DEPTH beats is always dropped.
- **Read side:** one output register stage, first-word-fall-through.
  - The output register loads when it is empty or when (m_axis_tvalid and m_axis_tready), provided empty=0.
  - m_axis_* stay stable while tvalid=1 and tready=0.
- **Reset (sys_reset=1):**
  - All pointers 0 and FSM in IDLE.
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0.
  - pkt_count=0, drop_count=0.
  - A frame in progress at reset release is treated as starting mid-frame: beats are discarded until the first tlast, with no count.

## Timing
- **Commit latency:** the last beat accepted in cycle T updates commit_ptr at the clock edge ending T. m_axis_tvalid for the frame's first beat rises in T+2 when the buffer was empty; the RAM read is registered.
- **Counter latency:** counters update one cycle after the deciding beat.
- **Throughput:** one output beat per cycle under continuous tready; one input beat per cycle always.
- **Rewind and read in the same cycle:** independent. rd_ptr never passes commit_ptr, so rewinds never corrupt data being read.
- **Commit while empty:** read-out starts on the next cycle.

## Test plan
- Single 1-beat frame, tkeep=all ones, tdata=0xA5…, tuser=0, tready=1 → identical beat with tlast=1 appears at T+2; pkt_count=1, drop_count=0.
- 3-beat frame with tuser=1 on tlast, then a 2-beat good frame → only the 2-beat frame emerges, bit-exact; drop_count=1, pkt_count=1.
- DEPTH=64, tready=0, five 16-beat good frames back to back → frames 1–4 committed and frame 5 dropped; drop_count=1. Raising tready yields 64 beats with tlast on beats 16, 32, 48 and 64.
- rx_aligned dropped at beat 3 of a 6-beat frame, restored before the next frame → frame dropped, drop_count=1; the next frame passes.
- 200 random frames (1–20 beats, random tuser) under random tready → output equals the in-order sequence of good frames; pkt_count + drop_count = 200; output stable whenever tvalid=1 and tready=0.
- sys_reset asserted mid-frame with 2 frames buffered → m_axis_tvalid=0 and counters 0 immediately. After release, the tail of the interrupted frame is discarded without a count, and the next full frame passes.

Source files
------------

// File: rtl/rx_pkt_drop_fifo.sv
// -----------------------------------------------------------------------------
// rx_pkt_drop_fifo
//
// Receive-side packet buffer between the CMAC RX stream, which cannot be
// backpressured, and the user RX pipeline. Every frame is written
// speculatively and becomes visible to the read side only once its last beat
// has arrived with a good FCS. Frames with a bad FCS, frames that arrive while
// the link is not aligned, and frames that overflow the buffer are discarded
// whole, so the user side never sees a partial frame.
//
// Ports
//   net_clk, sys_reset       clock; asynchronous active-high reset
//   rx_aligned               CMAC lane alignment status
//   s_axis_t*                CMAC RX stream (no tready); tuser = bad FCS,
//                            looked at only on the tlast beat
//   m_axis_t*                user RX stream, first-word-fall-through output
//   pkt_count, drop_count    saturating per-frame committed/dropped counters
// -----------------------------------------------------------------------------
module rx_pkt_drop_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    net_clk,
  input  logic                    sys_reset,
  input  logic                    rx_aligned,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    drop_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + KW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DROP
  } wstate_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Entry layout: {tlast, tkeep, tdata}
  logic [EW-1:0] mem [DEPTH];

  wstate_t              state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]        rd_ptr_q;
  logic                 sof_wait_q, sof_wait_d;
  logic                 in_frame_q;
  logic                 wr_en;
  logic                 pkt_inc;
  logic                 drop_inc;
  logic                 full;
  logic                 empty;
  logic                 load;
  logic                 out_vld_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KW-1:0]        out_keep_q;
  logic                 out_last_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  // Registered pointers only: a slot freed by this cycle's read is not reused
  // until the next cycle.
  assign full  = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
  assign empty = (rd_ptr_q == commit_ptr_q);

  // Tracks frame boundaries on the input stream independently of reset, so
  // that after reset release we know whether the line is mid-frame.
  always_ff @(posedge net_clk) begin
    if (s_axis_tvalid) begin
      in_frame_q <= ~s_axis_tlast;
    end
  end

  // Write-side FSM: next state, pointer updates and counter strobes.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    sof_wait_d   = sof_wait_q;
    wr_en        = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    if (s_axis_tvalid) begin
      if (sof_wait_q && in_frame_q) begin
        // Tail of a frame interrupted by reset: swallow silently.
        if (s_axis_tlast) begin
          sof_wait_d = 1'b0;
        end
      end else begin
        sof_wait_d = 1'b0;
        if (state_q == S_DROP) begin
          if (s_axis_tlast) begin
            state_d = S_IDLE;
          end
        end else if ((state_q == S_IDLE) && !rx_aligned) begin
          drop_inc = 1'b1;
          state_d  = s_axis_tlast ? S_IDLE : S_DROP;
        end else if (!rx_aligned || full) begin
          wr_ptr_d = commit_ptr_q;
          drop_inc = 1'b1;
          state_d  = s_axis_tlast ? S_IDLE : S_DROP;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (s_axis_tlast) begin
            state_d = S_IDLE;
            if (s_axis_tuser) begin
              wr_ptr_d = commit_ptr_q;
              drop_inc = 1'b1;
            end else begin
              commit_ptr_d = wr_ptr_q + PW'(1);
              pkt_inc      = 1'b1;
            end
          end else begin
            state_d = S_RECV;
          end
        end
      end
    end
  end

  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      sof_wait_q   <= 1'b1;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      sof_wait_q   <= sof_wait_d;
      if (pkt_inc) begin
        pkt_cnt_q <= sat_inc(pkt_cnt_q);
      end
      if (drop_inc) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

  always_ff @(posedge net_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  // Read side: the output register doubles as the RAM read register. It loads
  // whenever it is empty or being drained, so a stalled beat is held intact.
  assign load = !empty && (!out_vld_q || m_axis_tready);

  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      rd_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else if (load) begin
      rd_ptr_q                               <= rd_ptr_q + PW'(1);
      out_vld_q                              <= 1'b1;
      {out_last_q, out_keep_q, out_data_q}   <= mem[rd_ptr_q[AW-1:0]];
    end else if (m_axis_tready) begin
      out_vld_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign pkt_count     = pkt_cnt_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_rx_pkt_drop_fifo.sv
// -----------------------------------------------------------------------------
// tb_rx_pkt_drop_fifo
//
// Self-checking bench for rx_pkt_drop_fifo. A frame-level reference model
// decides per frame whether it is kept or dropped, queues the beats of kept
// frames, and keeps saturating expected counters. A monitor compares every
// output handshake against that queue and checks output hold under stall.
// -----------------------------------------------------------------------------
module tb_rx_pkt_drop_fifo;

  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 64;
  localparam int CW    = 8;
  localparam int BW    = DW + KW + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          net_clk;
  logic          sys_reset;
  logic          rx_aligned;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] drop_count;

  rx_pkt_drop_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .net_clk      (net_clk),
    .sys_reset    (sys_reset),
    .rx_aligned   (rx_aligned),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .pkt_count    (pkt_count),
    .drop_count   (drop_count)
  );

  initial net_clk = 1'b0;
  always #5 net_clk = ~net_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [BW-1:0] exp_q[$];
  int exp_pkt  = 0;
  int exp_drop = 0;
  int rdy_mode = 0;  // 0: never ready, 1: always ready, 2: random

  always @(posedge net_clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(0, 99) < 60);
    endcase
  end

  // Output monitor
  logic          prev_stall = 1'b0;
  logic [BW:0]   prev_out;
  always @(negedge net_clk) begin
    if (sys_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_val("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, prev_out);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0)
          check_val("extra_beat", exp_q.size(), 1);
        else
          check_val("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic l, input logic u);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    @(posedge net_clk);
    #1;
  endtask

  task automatic drive_idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) begin
      @(posedge net_clk);
      #1;
    end
  endtask

  // Sends one frame; alignment is lost from beat index drop_at onward
  // (negative: never). good states whether the model expects it delivered.
  task automatic send_frame(input int len, input logic user, input int drop_at, input logic good);
    logic [BW-1:0] fq[$];
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      l = (i == len - 1);
      k = l ? KW'($urandom_range(1, CMAX)) : '1;
      rx_aligned = (drop_at < 0) || (i < drop_at);
      fq.push_back({l, k, d});
      drive_beat(d, k, l, l ? user : 1'($urandom_range(0, 1)));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rx_aligned    = 1'b1;
    if (good) begin
      foreach (fq[i]) exp_q.push_back(fq[i]);
      if (exp_pkt < CMAX) exp_pkt++;
    end else begin
      if (exp_drop < CMAX) exp_drop++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge net_clk);
      #1;
      n++;
    end
    check_val(tag, exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_pkt"}, pkt_count, exp_pkt);
    check_val({tag, "_drop"}, drop_count, exp_drop);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base_pkt;
    int base_drop;
    int len;
    int da;
    int wt;
    logic usr;

    sys_reset     = 1'b1;
    rx_aligned    = 1'b1;
    m_axis_tready = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = 1'b0;
    // Line is between frames during reset: one end-of-frame beat on the wire.
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    repeat (3) @(posedge net_clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge net_clk);
    #1;
    check_val("rst_tvalid", m_axis_tvalid, 0);
    check_val("rst_tdata", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
    check_counts("rst");
    sys_reset = 1'b0;
    drive_idle(2);

    // Single 1-beat frame, first beat out at T+2
    rdy_mode = 1;
    drive_idle(1);
    exp_q.push_back({1'b1, {KW{1'b1}}, {(DW/8){8'hA5}}});
    exp_pkt++;
    drive_beat({(DW/8){8'hA5}}, '1, 1'b1, 1'b0);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check_val("t1_tvalid_T1", m_axis_tvalid, 0);
    check_counts("t1");
    @(posedge net_clk);
    #1;
    check_val("t1_tvalid_T2", m_axis_tvalid, 1);
    check_val("t1_beat_T2", {m_axis_tlast, m_axis_tkeep, m_axis_tdata},
              {1'b1, {KW{1'b1}}, {(DW/8){8'hA5}}});
    drive_idle(3);

    // Bad-FCS frame followed by a good one
    send_frame(3, 1'b1, -1, 1'b0);
    send_frame(2, 1'b0, -1, 1'b1);
    drive_idle(4);
    wait_drain("t2_drain");
    check_counts("t2");

    // Overflow: five 16-beat frames with no read-out
    rdy_mode = 0;
    drive_idle(2);
    for (int f = 0; f < 5; f++) send_frame(16, 1'b0, -1, f < 4);
    drive_idle(2);
    check_counts("t3");
    check_val("t3_stalled_valid", m_axis_tvalid, 1);
    rdy_mode = 1;
    wait_drain("t3_drain");
    drive_idle(2);
    check_val("t3_empty_after", m_axis_tvalid, 0);

    // Alignment lost at beat 3 of 6, next frame passes
    send_frame(6, 1'b0, 2, 1'b0);
    send_frame(4, 1'b0, -1, 1'b1);
    drive_idle(4);
    wait_drain("t4_drain");
    check_counts("t4");

    // Randomized frames under random ready
    rdy_mode  = 2;
    base_pkt  = exp_pkt;
    base_drop = exp_drop;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 20);
      usr = ($urandom_range(0, 3) == 0);
      da  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      wt  = 0;
      while (exp_q.size() + len > 60 && wt < 2000) begin
        drive_idle(1);
        wt++;
      end
      if (wt >= 2000) check_val("rand_throttle", exp_q.size(), 0);
      send_frame(len, usr, da, !usr && (da < 0));
      drive_idle($urandom_range(0, 2));
    end
    drive_idle(2);
    wait_drain("rand_drain");
    check_counts("rand");
    check_val("rand_total", (int'(pkt_count) - base_pkt) + (int'(drop_count) - base_drop), 200);

    // Reset in the middle of a frame with two frames buffered
    rdy_mode = 0;
    drive_idle(2);
    send_frame(3, 1'b0, -1, 1'b1);
    send_frame(3, 1'b0, -1, 1'b1);
    for (int i = 0; i < 3; i++) drive_beat({$urandom, $urandom}, '1, 1'b0, 1'b0);
    sys_reset = 1'b1;
    #1;
    check_val("rst2_tvalid", m_axis_tvalid, 0);
    check_val("rst2_pkt", pkt_count, 0);
    check_val("rst2_drop", drop_count, 0);
    exp_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    for (int i = 0; i < 2; i++) drive_beat({$urandom, $urandom}, '1, 1'b0, 1'b0);
    sys_reset = 1'b0;
    drive_beat({$urandom, $urandom}, '1, 1'b1, 1'b0);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drive_idle(2);
    check_counts("rst2_tail");
    rdy_mode = 1;
    send_frame(5, 1'b0, -1, 1'b1);
    drive_idle(4);
    wait_drain("rst2_drain");
    check_counts("rst2_next");

    // Drop counter saturation
    for (int f = 0; f < 260; f++) send_frame(1, 1'b1, -1, 1'b0);
    drive_idle(3);
    check_val("sat_drop", drop_count, CMAX);
    check_counts("sat");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
